// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipeline_stall_controller_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MD  = 2'd1,
    S_MEM = 2'd2
  } state_t;

  // True when a live (non-$0) destination feeds either Decode source operand.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
    return (dst != ZERO_REG) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter with enable; sticks at all-ones.
module stall_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard detection and stall/flush sequencing for the 5-stage pipe,
// including mult/div hold and data-memory wait states.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_D,
  input  logic [REG_W-1:0] Rt_D,
  input  logic [REG_W-1:0] Write_Reg_E,
  input  logic [REG_W-1:0] Write_Reg_M,
  input  logic             Reg_Write_E,
  input  logic             Mem_To_Reg_E,
  input  logic             Mem_To_Reg_M,
  input  logic             Branch_D,
  input  logic             Pc_Src_D,
  input  logic             Md_Op_E,
  input  logic             Dmem_Req_M,
  input  logic             Dmem_Ack,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_M,
  output logic             Md_Busy,
  output logic [CNT_W-1:0] Stall_Cycles
);

  localparam int MD_W = $clog2(MD_LATENCY);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 1);

  state_t          state_q, state_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            lwstall, brstall, memwait, mem_hold, md_busy;

  always_comb begin
    lwstall  = Mem_To_Reg_E & Reg_Write_E & reg_match(Write_Reg_E, Rs_D, Rt_D);
    brstall  = Branch_D & ((Reg_Write_E & reg_match(Write_Reg_E, Rs_D, Rt_D)) |
                           (Mem_To_Reg_M & reg_match(Write_Reg_M, Rs_D, Rt_D)));
    memwait  = Dmem_Req_M & ~Dmem_Ack;
    mem_hold = memwait | ((state_q == S_MEM) & ~Dmem_Ack);
    md_busy  = (md_cnt_q != '0);
  end

  // The mult/div count runs on regardless of memory waits, so the held
  // instruction sees the same total latency whether or not a wait overlaps.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_busy ? (md_cnt_q - MD_W'(1)) : md_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (memwait) begin
          state_d = S_MEM;
        end else if (Md_Op_E) begin
          state_d  = S_MD;
          md_cnt_d = MD_LOAD;
        end
      end
      S_MD: begin
        if (memwait)                     state_d = S_MEM;
        else if (md_cnt_q <= MD_W'(1))   state_d = S_RUN;
      end
      S_MEM: begin
        if (Dmem_Ack) state_d = (md_cnt_q <= MD_W'(1)) ? S_RUN : S_MD;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // A mult/div still counting keeps E held even on the memory-ack cycle.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_M = 1'b0;
    if (!reset) begin
      if (mem_hold) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
      end else if (md_busy) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Flush_M = 1'b1;
      end else if (lwstall | brstall) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end else if (Pc_Src_D) begin
        Flush_D = 1'b1;
      end
    end
  end

  assign Md_Busy = md_busy;

  stall_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .en    (Stall_F),
    .count (Stall_Cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push
// expected outputs, a negedge monitor pops and compares.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int CNT_W = 4;

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] HZ   = 8'b1100_0100;
  localparam logic [7:0] FLD  = 8'b0000_1000;
  localparam logic [7:0] MD   = 8'b1110_0011;
  localparam logic [7:0] MEMB = 8'b1111_0001;
  localparam logic [7:0] MEM  = 8'b1111_0000;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] Rs_D, Rt_D, Write_Reg_E, Write_Reg_M;
  logic Reg_Write_E, Mem_To_Reg_E, Mem_To_Reg_M, Branch_D, Pc_Src_D;
  logic Md_Op_E, Dmem_Req_M, Dmem_Ack;
  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Md_Busy;
  logic [CNT_W-1:0] Stall_Cycles;

  pipeline_stall_controller #(.MD_LATENCY(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs_D(Rs_D), .Rt_D(Rt_D),
    .Write_Reg_E(Write_Reg_E), .Write_Reg_M(Write_Reg_M),
    .Reg_Write_E(Reg_Write_E), .Mem_To_Reg_E(Mem_To_Reg_E),
    .Mem_To_Reg_M(Mem_To_Reg_M), .Branch_D(Branch_D), .Pc_Src_D(Pc_Src_D),
    .Md_Op_E(Md_Op_E), .Dmem_Req_M(Dmem_Req_M), .Dmem_Ack(Dmem_Ack),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
    .Md_Busy(Md_Busy), .Stall_Cycles(Stall_Cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0]       outs;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  function automatic logic [7:0] obs();
    return {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Md_Busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, "/outs"}, 32'(obs()), 32'(e.outs));
      check({e.name, "/cnt"}, 32'(Stall_Cycles), 32'(e.cnt));
    end
  end

  task automatic idle();
    Rs_D = '0; Rt_D = '0; Write_Reg_E = '0; Write_Reg_M = '0;
    Reg_Write_E = 0; Mem_To_Reg_E = 0; Mem_To_Reg_M = 0; Branch_D = 0;
    Pc_Src_D = 0; Md_Op_E = 0; Dmem_Req_M = 0; Dmem_Ack = 0;
  endtask

  task automatic apply(input string name, input logic [7:0] outs);
    exp_t e;
    e.name = name;
    e.outs = outs;
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    if (outs[7] && (model_cnt != '1)) model_cnt = model_cnt + CNT_W'(1);
    @(posedge clk); #1;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] rs,
                              input logic [REG_W-1:0] rt);
    idle();
    Mem_To_Reg_E = 1; Reg_Write_E = 1; Write_Reg_E = dst; Rs_D = rs; Rt_D = rt;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    set_load_use(5'd5, 5'd5, 5'd0);
    #1;
    check("rst_hold/outs", 32'(obs()), 32'(NONE));
    check("rst_hold/cnt", 32'(Stall_Cycles), 32'd0);
    idle();
    reset = 0;
    apply("post_rst", NONE);

    set_load_use(5'd5, 5'd5, 5'd0);  apply("lu_rs", HZ);
    idle();                          apply("lu_bubble", NONE);
    set_load_use(5'd9, 5'd1, 5'd9);  apply("lu_rt", HZ);
    set_load_use(5'd0, 5'd0, 5'd0);  apply("lu_r0", NONE);
    set_load_use(5'd4, 5'd3, 5'd2);  apply("lu_nomatch", NONE);

    idle(); Branch_D = 1; Rt_D = 7; Mem_To_Reg_M = 1; Write_Reg_M = 7;
    apply("br_m_load", HZ);
    idle(); Branch_D = 1; Rs_D = 3; Reg_Write_E = 1; Write_Reg_E = 3;
    apply("br_e_alu", HZ);
    idle(); Branch_D = 1; Rt_D = 7; Write_Reg_M = 7;
    apply("br_m_alu", NONE);
    idle(); Pc_Src_D = 1;
    apply("pcsrc", FLD);
    set_load_use(5'd6, 5'd6, 5'd0); Pc_Src_D = 1;
    apply("pcsrc_lu", HZ);

    // mult/div, Md_Op_E left high during busy
    idle(); Md_Op_E = 1;
    apply("md_launch", NONE);
    for (int i = 0; i < 7; i++) apply($sformatf("md_busy%0d", i), MD);
    idle();
    apply("md_done", NONE);

    idle(); Dmem_Req_M = 1;
    for (int i = 0; i < 3; i++) apply($sformatf("mw%0d", i), MEM);
    Dmem_Ack = 1;
    apply("mw_ack", NONE);
    idle();
    apply("mw_after", NONE);

    // short memory wait inside mult/div
    idle(); Md_Op_E = 1;
    apply("ov1_launch", NONE);
    apply("ov1_md1", MD);
    apply("ov1_md2", MD);
    Dmem_Req_M = 1;
    apply("ov1_mw1", MEMB);
    apply("ov1_mw2", MEMB);
    Dmem_Ack = 1;
    apply("ov1_ack", MD);
    Dmem_Req_M = 0; Dmem_Ack = 0;
    apply("ov1_md6", MD);
    apply("ov1_md7", MD);
    idle();
    apply("ov1_done", NONE);

    // long memory wait outlasting mult/div
    idle(); Md_Op_E = 1;
    apply("ov2_launch", NONE);
    Md_Op_E = 0;
    apply("ov2_md1", MD);
    apply("ov2_md2", MD);
    Dmem_Req_M = 1;
    for (int i = 0; i < 5; i++) apply($sformatf("ov2_mwb%0d", i), MEMB);
    for (int i = 0; i < 5; i++) apply($sformatf("ov2_mw%0d", i), MEM);
    Dmem_Ack = 1;
    apply("ov2_ack", NONE);
    idle();
    apply("ov2_run", NONE);

    // async reset mid-busy
    idle(); Md_Op_E = 1;
    apply("ar_launch", NONE);
    Md_Op_E = 0;
    apply("ar_md1", MD);
    apply("ar_md2", MD);
    set_load_use(5'd5, 5'd5, 5'd0);
    reset = 1;
    #1;
    check("async_rst/outs", 32'(obs()), 32'(NONE));
    check("async_rst/cnt", 32'(Stall_Cycles), 32'd0);
    idle();
    @(posedge clk); #1;
    reset = 0;
    model_cnt = '0;
    apply("ar_run", NONE);
    set_load_use(5'd8, 5'd0, 5'd8);
    apply("ar_lu", HZ);
    idle();
    apply("ar_cnt1", NONE);

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
